pwm_fade_array: RTL and testbench

//   Parametrised N-channel PWM generator with a per-channel linear fade engine (duty ramps toward a target).

---
 rtl/pwm_fade_array_pkg.sv | 18 +
 rtl/pwm_fade_array_if.sv | 25 ++
 rtl/pwm_fade_array_chan.sv | 71 +++++++
 rtl/pwm_fade_array.sv | 77 +++++++
 tb/tb_pwm_fade_array.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_fade_array_pkg.sv
// Shared constants and types for the PWM fade array.
// No ports: clock rate, default sizing, duty type, channel-index width helper.
package pwm_fade_array_pkg;

    localparam int CLK_HZ       = 125_000_000;
    localparam int DEF_CHANNELS = 3;
    localparam int DEF_RES      = 8;
    localparam int DEF_PRESCALE = 490;
    localparam int DEF_RATE_W   = 8;

    typedef logic [DEF_RES-1:0] duty_t;

    // Channel index width, never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_fade_array_if.sv
// Command port bundle: valid/ready handshake carrying channel, target, rate.
// master drives valid/chan/target/rate; slave returns ready.
interface pwm_fade_array_if #(
    parameter int CW     = 2,
    parameter int RES    = 8,
    parameter int RATE_W = 8
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CW-1:0]     cmd_chan;
    logic [RES-1:0]    cmd_target;
    logic [RATE_W-1:0] cmd_rate;

    modport master (
        output cmd_valid, cmd_chan, cmd_target, cmd_rate,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_chan, cmd_target, cmd_rate,
        output cmd_ready
    );

endinterface

// File: rtl/pwm_fade_array_chan.sv
// One PWM channel: target/rate store, linear fade stepped at period wraps,
// duty compare and busy flag. Ports: clk, reset, cnt_i, wrap_i, load_i,
// target_i, rate_i in; pwm_o, busy_o out (both registered).
module pwm_fade_array_chan #(
    parameter int RES    = 8,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RES-1:0]    cnt_i,
    input  logic              wrap_i,
    input  logic              load_i,
    input  logic [RES-1:0]    target_i,
    input  logic [RATE_W-1:0] rate_i,
    output logic              pwm_o,
    output logic              busy_o
);

    logic [RES-1:0]    duty_q, duty_d;
    logic [RES-1:0]    target_q, target_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] rcnt_q, rcnt_d;
    logic              pwm_q, busy_q;

    always_comb begin
        duty_d   = duty_q;
        target_d = target_q;
        rate_d   = rate_q;
        rcnt_d   = rcnt_q;
        // Fade sees the pre-command target/rate; a command landing on the
        // same edge only takes effect from the following wrap.
        if (wrap_i && (duty_q != target_q)) begin
            if (rate_q == '0) begin
                duty_d = target_q;
            end else if (rcnt_q == '0) begin
                duty_d = (target_q > duty_q) ? duty_q + 1'b1
                                             : duty_q - 1'b1;
                rcnt_d = rate_q - 1'b1;
            end else begin
                rcnt_d = rcnt_q - 1'b1;
            end
        end
        if (load_i) begin
            target_d = target_i;
            rate_d   = rate_i;
            rcnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_q   <= '0;
            target_q <= '0;
            rate_q   <= '0;
            rcnt_q   <= '0;
            pwm_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            target_q <= target_d;
            rate_q   <= rate_d;
            rcnt_q   <= rcnt_d;
            pwm_q    <= (cnt_i < duty_q);
            busy_q   <= (duty_q != target_q);
        end
    end

    assign pwm_o  = pwm_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/pwm_fade_array.sv
// N-channel PWM with per-channel linear fade: shared prescaler and period
// counter, command decode, one fade channel per output. Ports: clk, reset,
// cmd (slave command bundle), pwm_out, busy, period_tick.
module pwm_fade_array
    import pwm_fade_array_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int RES      = DEF_RES,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int RATE_W   = DEF_RATE_W
) (
    input  logic                clk,
    input  logic                reset,
    pwm_fade_array_if.slave     cmd,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] busy,
    output logic                period_tick
);

    localparam int CW       = chan_w(CHANNELS);
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CNT_LAST = 2**RES - 2;

    logic [PW-1:0]  pre_q, pre_d;
    logic [RES-1:0] cnt_q, cnt_d;
    logic           tick_q, ready_q;
    logic           tick, wrap, accept;

    assign tick   = (pre_q == PW'(PRESCALE - 1));
    assign wrap   = tick && (cnt_q == RES'(CNT_LAST));
    assign accept = cmd.cmd_valid && ready_q;

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            tick_q  <= wrap;
            ready_q <= 1'b1;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign period_tick   = tick_q;

    // Out-of-range channel indices match no instance, so the command is
    // consumed by the handshake and otherwise dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pwm_fade_array_chan #(
            .RES    (RES),
            .RATE_W (RATE_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .cnt_i    (cnt_q),
            .wrap_i   (wrap),
            .load_i   (accept && (cmd.cmd_chan == CW'(i))),
            .target_i (cmd.cmd_target),
            .rate_i   (cmd.cmd_rate),
            .pwm_o    (pwm_out[i]),
            .busy_o   (busy[i])
        );
    end

endmodule

// File: tb/tb_pwm_fade_array.sv
// Self-checking bench for pwm_fade_array (3 channels, RES=4, PRESCALE=2).
// Reference model predicts outputs from edge count and fade rules.
module tb_pwm_fade_array;

    localparam int CH  = 3;
    localparam int RES = 4;
    localparam int PRE = 2;
    localparam int RW  = 4;
    localparam int NT  = 15;
    localparam int PER = NT * PRE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #4 clk = ~clk;

    pwm_fade_array_if #(.CW(2), .RES(RES), .RATE_W(RW)) cmd_if ();

    logic [CH-1:0] pwm_out, busy;
    logic          period_tick;

    pwm_fade_array #(
        .CHANNELS (CH),
        .RES      (RES),
        .PRESCALE (PRE),
        .RATE_W   (RW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd_if),
        .pwm_out     (pwm_out),
        .busy        (busy),
        .period_tick (period_tick)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: m_e = clock edges since reset release. Before edge m_e+1 the
    // period counter holds (m_e/PRE)%NT; edges that are multiples of PER wrap.
    int         m_e;
    int         m_duty [CH];
    int         m_tgt  [CH];
    int         m_rate [CH];
    int         m_rc   [CH];
    logic [CH-1:0] m_pwm, m_busy;
    logic       m_tick, m_ready;
    wire        m_wrap = ((m_e + 1) % PER) == 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_e     <= 0;
            m_pwm   <= '0;
            m_busy  <= '0;
            m_tick  <= 1'b0;
            m_ready <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_duty[i] <= 0;
                m_tgt[i]  <= 0;
                m_rate[i] <= 0;
                m_rc[i]   <= 0;
            end
        end else begin
            m_e     <= m_e + 1;
            m_ready <= 1'b1;
            m_tick  <= m_wrap;
            for (int i = 0; i < CH; i++) begin
                m_pwm[i]  <= ((m_e / PRE) % NT) < m_duty[i];
                m_busy[i] <= m_duty[i] != m_tgt[i];
                if (m_wrap && m_duty[i] != m_tgt[i]) begin
                    if (m_rate[i] == 0) begin
                        m_duty[i] <= m_tgt[i];
                    end else if (m_rc[i] == 0) begin
                        m_duty[i] <= m_duty[i] + ((m_tgt[i] > m_duty[i]) ? 1 : -1);
                        m_rc[i]   <= m_rate[i] - 1;
                    end else begin
                        m_rc[i] <= m_rc[i] - 1;
                    end
                end
                if (cmd_if.cmd_valid && m_ready && int'(cmd_if.cmd_chan) == i) begin
                    m_tgt[i]  <= int'(cmd_if.cmd_target);
                    m_rate[i] <= int'(cmd_if.cmd_rate);
                    m_rc[i]   <= 0;
                end
            end
        end
    end

    wire [7:0] dut_vec = {pwm_out, busy, period_tick, cmd_if.cmd_ready};
    wire [7:0] exp_vec = {m_pwm, m_busy, m_tick, m_ready};

    task automatic send(input int ch, input int tg, input int rt);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_chan   = 2'(ch);
        cmd_if.cmd_target = 4'(tg);
        cmd_if.cmd_rate   = 4'(rt);
        @(negedge clk);
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        int ticks = 0;
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== 8'h00) begin
                n_err++;
                $display("FAIL reset_hold: got %b want 00000000", dut_vec);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready);
        end
        repeat (3 * PER) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL reset_run: got %b want %b", dut_vec, exp_vec);
            end
            if (period_tick) ticks++;
        end
        n_chk++;
        if (ticks != 3) begin
            n_err++;
            $display("FAIL reset_ticks: got %0d want 3", ticks);
        end
    endtask

    task automatic test_jump();
        int k = 0;
        int hi = 0;
        send(0, 8, 0);
        do begin
            @(negedge clk);
            k++;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL jump_wait: got %b want %b", dut_vec, exp_vec);
            end
        end while (!period_tick && k < 2 * PER);
        n_chk++;
        if (!period_tick || busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL jump_tick: tick=%b busy0=%b want 1 1", period_tick, busy[0]);
        end
        repeat (PER) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL jump_run: got %b want %b", dut_vec, exp_vec);
            end
            hi += int'(pwm_out[0]);
        end
        n_chk++;
        if (hi != 16 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL jump_high: high=%0d busy0=%b want 16 0", hi, busy[0]);
        end
    endtask

    task automatic test_ramp();
        int k = 0;
        int hi = 0;
        send(1, 15, 2);
        do begin
            @(negedge clk);
            k++;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL ramp_wait: got %b want %b", dut_vec, exp_vec);
            end
        end while (busy[1] && k < 40 * PER);
        n_chk++;
        if (busy[1] !== 1'b0 || k < 28 * PER) begin
            n_err++;
            $display("FAIL ramp_time: busy1=%b cycles=%0d want 0 >=%0d", busy[1], k, 28 * PER);
        end
        repeat (PER) begin
            @(negedge clk);
            hi += int'(pwm_out[1]);
        end
        n_chk++;
        if (hi != PER) begin
            n_err++;
            $display("FAIL ramp_full: high=%0d want %0d", hi, PER);
        end
    endtask

    task automatic test_reverse();
        int k = 0;
        int exp_hi [3] = '{8, 6, 4};
        send(2, 12, 1);
        do begin
            @(negedge clk);
            k++;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL rev_wait: got %b want %b", dut_vec, exp_vec);
            end
        end while (m_duty[2] != 5 && k < 10 * PER);
        send(2, 2, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_tick && k < 2 * PER);
        for (int j = 0; j < 3; j++) begin
            int hi = 0;
            repeat (PER) begin
                @(negedge clk);
                n_chk++;
                if (dut_vec !== exp_vec) begin
                    n_err++;
                    $display("FAIL rev_run: got %b want %b", dut_vec, exp_vec);
                end
                hi += int'(pwm_out[2]);
            end
            n_chk++;
            if (hi != exp_hi[j]) begin
                n_err++;
                $display("FAIL rev_step%0d: high=%0d want %0d", j, hi, exp_hi[j]);
            end
        end
        n_chk++;
        if (busy[2] !== 1'b0) begin
            n_err++;
            $display("FAIL rev_busy: got %b want 0", busy[2]);
        end
    endtask

    task automatic test_collision();
        int k = 0;
        int hi;
        do begin
            @(negedge clk);
            k++;
        end while (!period_tick && k < 2 * PER);
        send(0, 12, 0);
        k = 0;
        while (m_e % PER != PER - 1 && k < 2 * PER) begin
            @(negedge clk);
            k++;
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL coll_wait: got %b want %b", dut_vec, exp_vec);
            end
        end
        send(0, 0, 0);
        for (int j = 0; j < 2; j++) begin
            hi = 0;
            repeat (PER) begin
                @(negedge clk);
                n_chk++;
                if (dut_vec !== exp_vec) begin
                    n_err++;
                    $display("FAIL coll_run: got %b want %b", dut_vec, exp_vec);
                end
                hi += int'(pwm_out[0]);
            end
            n_chk++;
            if (hi != (j == 0 ? 24 : 0) || busy[0] !== (j == 0)) begin
                n_err++;
                $display("FAIL coll_period%0d: high=%0d busy0=%b want %0d %b",
                         j, hi, busy[0], (j == 0 ? 24 : 0), (j == 0));
            end
        end
    endtask

    task automatic test_bad_chan();
        int hi = 0;
        send(3, 15, 0);
        repeat (2 * PER) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL bad_run: got %b want %b", dut_vec, exp_vec);
            end
            hi += int'(pwm_out[0]);
        end
        n_chk++;
        if (hi != 0 || busy !== 3'b000) begin
            n_err++;
            $display("FAIL bad_chan: high0=%0d busy=%b want 0 000", hi, busy);
        end
    endtask

    task automatic test_mid_reset();
        int hi = 0;
        send(0, 15, 1);
        repeat (5 * PER) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL mrst_run: got %b want %b", dut_vec, exp_vec);
            end
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (dut_vec !== 8'h00) begin
            n_err++;
            $display("FAIL mrst_async: got %b want 00000000", dut_vec);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * PER) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL mrst_after: got %b want %b", dut_vec, exp_vec);
            end
            hi += int'(|pwm_out) + int'(|busy);
        end
        n_chk++;
        if (hi != 0) begin
            n_err++;
            $display("FAIL mrst_zero: active=%0d want 0", hi);
        end
    endtask

    task automatic test_random();
        repeat (25) begin
            repeat ($urandom_range(0, 40)) begin
                @(negedge clk);
                n_chk++;
                if (dut_vec !== exp_vec) begin
                    n_err++;
                    $display("FAIL rand_run: got %b want %b", dut_vec, exp_vec);
                end
            end
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)));
        end
        repeat (50 * PER) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL rand_settle: got %b want %b", dut_vec, exp_vec);
            end
        end
        n_chk++;
        if (busy !== 3'b000) begin
            n_err++;
            $display("FAIL rand_idle: busy=%b want 000", busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_chan   = '0;
        cmd_if.cmd_target = '0;
        cmd_if.cmd_rate   = '0;
        test_reset();
        test_jump();
        test_ramp();
        test_reverse();
        test_collision();
        test_bad_chan();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
